// File: rtl/pma_loopback_channel_pkg.sv
// ============================================================================
//  Package     : eth_pcs_params
//  Description : Shared sizing constants for the Ethernet PCS/PMA test path.
//                W_DATA        - PMA word width in bits
//                MAX_PMA_DELAY - deepest word delay the loopback channel adds
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pcs_params;

    localparam int W_DATA        = 32;
    localparam int MAX_PMA_DELAY = 8;

endpackage : eth_pcs_params

`default_nettype wire

// File: rtl/pma_loopback_channel_delay.sv
// ============================================================================
//  Module      : pma_delay_line
//  Description : MAX_DELAY-deep word shift register with a selectable tap.
//                Tap 0 is a straight combinational pass-through; tap k returns
//                the word that entered k cycles earlier.
//  Ports       : i_clk     - clock, rising edge
//                i_reset_n - synchronous active-low reset, clears every stage
//                i_data    - word entering the line
//                i_tap     - delay select, 0..MAX_DELAY
//                o_data    - selected word
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pma_delay_line #(
    parameter int W_DATA    = eth_pcs_params::W_DATA,
    parameter int MAX_DELAY = eth_pcs_params::MAX_PMA_DELAY
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic [W_DATA-1:0]                  i_data,
    input  logic [$clog2(MAX_DELAY+1)-1:0]     i_tap,
    output logic [W_DATA-1:0]                  o_data
);

    localparam int c_DW = $clog2(MAX_DELAY + 1);

    logic [W_DATA-1:0] r_stage [1:MAX_DELAY];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[1] <= i_data;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_comb begin
        o_data = i_data;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (i_tap == c_DW'(k)) begin
                o_data = r_stage[k];
            end
        end
    end

endmodule : pma_delay_line

`default_nettype wire

// File: rtl/pma_loopback_channel.sv
// ============================================================================
//  Module      : pma_loopback_channel
//  Description : PMA loopback channel model. Registers the TX word, applies a
//                bit slip across the word boundary, adds a selectable word
//                delay and blanks the output while the pipeline refills after
//                a configuration load or reset. Optional bit-error injection
//                is compiled in only when PMA_ERR_INJECT_EN is defined.
//  Ports       : i_clk, i_reset_n (sync, active low)
//                i_tx_pma_data  - TX word, LSB first on the line
//                i_cfg_load     - latches i_slip / i_delay
//                i_slip         - bit-slip amount
//                i_delay        - added word delay, clamped to MAX_DELAY
//                i_err_en       - enable error injection
//                i_err_period   - words between injected errors, 0 = off
//                o_rx_pma_data  - RX word (zero while o_valid is low)
//                o_valid        - RX word carries channel data
//                o_err_cnt      - saturating count of injected errors
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pma_loopback_channel #(
    parameter int W_DATA    = eth_pcs_params::W_DATA,
    parameter int MAX_DELAY = eth_pcs_params::MAX_PMA_DELAY
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic [W_DATA-1:0]                  i_tx_pma_data,
    input  logic                               i_cfg_load,
    input  logic [$clog2(W_DATA)-1:0]          i_slip,
    input  logic [$clog2(MAX_DELAY+1)-1:0]     i_delay,
    input  logic                               i_err_en,
    input  logic [15:0]                        i_err_period,
    output logic [W_DATA-1:0]                  o_rx_pma_data,
    output logic                               o_valid,
    output logic [15:0]                        o_err_cnt
);

    localparam int              c_SW      = $clog2(W_DATA);
    localparam int              c_DW      = $clog2(MAX_DELAY + 1);
    localparam logic [c_DW-1:0] c_MAX_TAP = c_DW'(MAX_DELAY);

    logic [W_DATA-1:0] r_cur;
    logic [W_DATA-1:0] r_prev;
    logic [c_SW-1:0]   r_slip;
    logic [c_DW-1:0]   r_delay;
    logic [c_DW:0]     r_flush;      // cycles left before output is valid

    logic [c_DW-1:0]   w_delay_clamped;
    logic [W_DATA-1:0] w_slipped;
    logic [W_DATA-1:0] w_tap;
    logic [W_DATA-1:0] w_err_mask;
    logic              w_valid;

    assign w_delay_clamped = (i_delay > c_MAX_TAP) ? c_MAX_TAP : i_delay;

    // Window of W_DATA bits ending s bits into cur; s = 0 selects cur whole.
    assign w_slipped = W_DATA'({r_cur, r_prev} >> (W_DATA - int'(r_slip)));

    // Two words refill cur/prev, then D more refill the chosen tap.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cur   <= '0;
            r_prev  <= '0;
            r_slip  <= '0;
            r_delay <= '0;
            r_flush <= (c_DW+1)'(2);
        end else begin
            r_cur  <= i_tx_pma_data;
            r_prev <= r_cur;
            if (i_cfg_load) begin
                r_slip  <= i_slip;
                r_delay <= w_delay_clamped;
                r_flush <= {1'b0, w_delay_clamped} + (c_DW+1)'(2);
            end else if (r_flush != '0) begin
                r_flush <= r_flush - (c_DW+1)'(1);
            end
        end
    end

    pma_delay_line #(
        .W_DATA    (W_DATA),
        .MAX_DELAY (MAX_DELAY)
    ) u_delay (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_data    (w_slipped),
        .i_tap     (r_delay),
        .o_data    (w_tap)
    );

    assign w_valid       = (r_flush == '0);
    assign o_valid       = w_valid;
    assign o_rx_pma_data = w_valid ? (w_tap ^ w_err_mask) : '0;

`ifdef PMA_ERR_INJECT_EN
    logic [15:0]     r_word_cnt;
    logic [15:0]     r_err_cnt;
    logic [15:0]     r_period;     // previous period, to detect a change
    logic [c_SW-1:0] r_err_bit;
    logic            w_cnt_clear;
    logic            w_cnt_en;
    logic            w_inject;

    // A config load clears the count, so it also suppresses injection.
    assign w_cnt_clear = !i_err_en || (i_err_period != r_period) || i_cfg_load;
    assign w_cnt_en    = w_valid && i_err_en && (i_err_period != 16'd0);
    assign w_inject    = w_cnt_en && !w_cnt_clear &&
                         (r_word_cnt == i_err_period - 16'd1);
    assign w_err_mask  = w_inject ? (W_DATA'(1) << r_err_bit) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
            r_period   <= '0;
            r_err_bit  <= '0;
        end else begin
            r_period <= i_err_period;
            if (w_cnt_clear) begin
                r_word_cnt <= '0;
            end else if (w_inject) begin
                r_word_cnt <= '0;
                r_err_bit  <= (r_err_bit == c_SW'(W_DATA - 1)) ? '0
                                                               : r_err_bit + c_SW'(1);
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end else if (w_cnt_en) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = &{1'b0, i_err_en, i_err_period};
    assign w_err_mask   = '0;
    assign o_err_cnt    = 16'd0;
`endif

endmodule : pma_loopback_channel

`default_nettype wire

// File: doc/pma_loopback_channel.md
PMA_LOOPBACK_CHANNEL -- requirements
Module: pma_loopback_channel

Interface
REQ-001 SHALL have parameter W_DATA, default eth_pcs_params::W_DATA (32), PMA word width in bits.
REQ-002 SHALL have parameter MAX_DELAY, default eth_pcs_params::MAX_PMA_DELAY (8), maximum added word delay.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_tx_pma_data  input  W_DATA  TX PMA word, LSB transmitted first.
REQ-006 SHALL have port i_cfg_load  input  1  single-cycle pulse that latches i_slip and i_delay.
REQ-007 SHALL have port i_slip  input  $clog2(W_DATA)  bit-slip amount s, 0..W_DATA-1.
REQ-008 SHALL have port i_delay  input  $clog2(MAX_DELAY+1)  added word delay D, 0..MAX_DELAY; values above MAX_DELAY are clamped to MAX_DELAY.
REQ-009 SHALL have port i_err_en  input  1  enables bit-error injection.
REQ-010 SHALL have port i_err_period  input  16  words between injected errors; 0 disables injection.
REQ-011 SHALL have port o_rx_pma_data  output  W_DATA  RX PMA word.
REQ-012 SHALL have port o_valid  output  1  high when o_rx_pma_data carries channel data.
REQ-013 SHALL have port o_err_cnt  output  16  count of injected errors.

Function
REQ-014 SHALL model the line as a bit stream: slip stage output = bits [2*W_DATA-1-s : W_DATA-s] of {cur, prev}, where cur is the registered TX word and prev is the word before it; s=0 gives cur.
REQ-015 SHALL give total latency from i_tx_pma_data to o_rx_pma_data of 1+D cycles for s=0.
REQ-016 SHALL build the delay path as MAX_DELAY register stages with the output tap selected by the latched D.
REQ-017 SHALL latch s and D on the cycle i_cfg_load is high; the new values take effect the following cycle.
REQ-018 SHALL deassert o_valid for exactly 2+D_new cycles after i_cfg_load, then hold it high.
REQ-019 SHALL drive o_rx_pma_data to all zeros while o_valid is low.
REQ-020 SHALL, in injection, count words with o_valid=1 and i_err_en=1; when the count reaches i_err_period-1, invert bit b of that output word, reset the count to 0, and increment b modulo W_DATA.
REQ-021 SHALL increment o_err_cnt by 1 per injected error, saturating at 16'hFFFF.
REQ-022 SHALL clear the word counter when i_err_en is low, i_err_period changes, or i_cfg_load is high; b and o_err_cnt are kept.
REQ-023 SHALL give i_cfg_load priority when it coincides with an injection cycle: the word in that cycle is not corrupted.

Reset
REQ-024 SHALL, while i_reset_n=0 at a clock edge, clear s=0, D=0, all data stages, the word counter, b=0, and o_err_cnt=0.
REQ-025 SHALL hold o_rx_pma_data=0 and o_valid=0 during reset.
REQ-026 SHALL, after reset release, behave as a config load with s=0 and D=0 (o_valid high after 2 cycles).
REQ-027 SHALL make reset mid-flush or mid-injection abandon all state with no partial output.

Configuration
REQ-028 SHALL compile in error injection (REQ-020..023) only when macro PMA_ERR_INJECT_EN is defined.
REQ-029 SHALL, without PMA_ERR_INJECT_EN, keep all ports, ignore i_err_en and i_err_period, tie o_err_cnt to 0, and infer no injection logic.

Structure
REQ-030 SHALL take W_DATA and MAX_PMA_DELAY from package eth_pcs_params; no local redefinition.
REQ-031 SHALL place the tap-selectable register chain in one sub-module, pma_delay_line (parameters W_DATA and MAX_DELAY; ports i_clk, i_reset_n, data in, tap select, data out).
REQ-032 SHALL keep slip, valid control and injection in pma_loopback_channel.

Verification
REQ-033 SHALL test: reset release with s=0, D=0, TX words 0x1,0x2,0x3 on consecutive cycles -> o_valid high from cycle 2, RX 0x1,0x2,0x3 at 1-cycle latency.
REQ-034 SHALL test: load s=1, D=0, TX 0x80000000 then 0x00000000 (W_DATA=32) -> after flush, RX word contains 0x00000001 one word later.
REQ-035 SHALL test: load D=5 -> o_valid low for exactly 7 cycles, then a marker word 0xA5A5A5A5 appears 6 cycles after input.
REQ-036 SHALL test: i_delay=15 with MAX_DELAY=8 -> latency 9 cycles (clamped).
REQ-037 SHALL test, with PMA_ERR_INJECT_EN: i_err_en=1, period=4, TX all zeros -> every 4th valid RX word has exactly one bit set, bits 0,1,2,... in order, and o_err_cnt reaches 3 after 12 valid words.
REQ-038 SHALL test, without PMA_ERR_INJECT_EN: the same stimulus -> RX all zeros and o_err_cnt=0.
